uart_rx_byte: RTL and testbench

- Serial UART receiver on the far side of the link driven by the board's UART transmit path.
- Consumes the asynchronous serial line (8N1, LSB first) and recovers bytes, flagging framing errors.
- Emits a one-cycle valid strobe per good byte, drives an activity LED, and keeps a count of received bytes.
- Downstream blocks, such as a receive FIFO or 7-segment decoder, consume o_rx_valid/o_rx_data directly.

---
 rtl/uart_rx_byte.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_byte.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: recovers LSB-first bytes from an asynchronous line,
// strobes good bytes and framing errors, stretches an activity LED and counts bytes.
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int LED_HOLD = 5_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_data,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_frame_err,
  output logic       o_busy,
  output logic       o_led_rx,
  output logic [7:0] o_rx_cnt
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);
  localparam int LED_W = $clog2(LED_HOLD + 1);

  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [LED_W-1:0] LED_RELOAD = LED_W'(LED_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_next;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic [LED_W-1:0] led_timer;
  logic             good_byte, bad_stop;

  // Two-flop synchronizer; idle line is high, so the flops reset to 1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx_data;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
    end
  end

  // Start bit is re-checked at its middle; data and stop bits are sampled one
  // full bit period later each, i.e. at their centres.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    good_byte    = 1'b0;
    bad_stop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_next = S_START;
          cnt_next   = '0;
        end
      end
      S_START: begin
        if (cnt == HALF_M1) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next   = S_DATA;
            bit_idx_next = '0;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == DIV_M1) begin
          shift_next[bit_idx] = rx_s;
          cnt_next            = '0;
          bit_idx_next        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = S_STOP;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt == DIV_M1) begin
          cnt_next = '0;
          if (rx_s) begin
            good_byte  = 1'b1;
            state_next = S_IDLE;
          end else begin
            bad_stop   = 1'b1;
            state_next = S_BREAK;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (rx_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Registered strobes, held byte, counter and busy decode of the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      o_rx_data   <= 8'h00;
      o_rx_cnt    <= 8'h00;
      o_busy      <= 1'b0;
    end else begin
      o_rx_valid  <= good_byte;
      o_frame_err <= bad_stop;
      o_busy      <= (state_next != S_IDLE);
      if (good_byte) begin
        o_rx_data <= shift;
        o_rx_cnt  <= o_rx_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      led_timer <= '0;
    end else if (good_byte) begin
      led_timer <= LED_RELOAD;
    end else if (led_timer != '0) begin
      led_timer <= led_timer - LED_W'(1);
    end
  end

  assign o_led_rx = (led_timer != '0) || good_byte;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed plus randomized bench for uart_rx_byte; a byte-level model predicts
// strobe timing (E + 2 + HALF + 9*DIV), data, counter and LED stretch.
module tb_uart_rx_byte;

  localparam int DIV      = 16;
  localparam int HALF     = 8;
  localparam int LED_HOLD = 20;
  localparam int LAT      = 2 + HALF + 9 * DIV;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       busy;
  logic       led_rx;
  logic [7:0] rx_cnt;

  uart_rx_byte #(.CLK_FREQ(16), .BAUD(1), .LED_HOLD(LED_HOLD)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rx),
    .o_rx_valid (rx_valid),
    .o_rx_data  (rx_data),
    .o_frame_err(frame_err),
    .o_busy     (busy),
    .o_led_rx   (led_rx),
    .o_rx_cnt   (rx_cnt)
  );

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic [7:0] cnt;
    logic       led;
  } rec_t;

  rec_t valid_q[$];
  int   err_q[$];
  int   cyc;
  int   led_high;
  int   both_high;
  int   passed;
  int   total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) valid_q.push_back('{cyc: cyc, data: rx_data, cnt: rx_cnt, led: led_rx});
    if (frame_err) err_q.push_back(cyc);
    if (led_rx) led_high = led_high + 1;
    if (rx_valid && frame_err) both_high = both_high + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic sendBit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (DIV - 1) @(negedge clk);
  endtask

  // One 8N1 frame; startEdge is the first posedge that samples the start bit.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, output int startEdge);
    @(negedge clk);
    rx = 1'b0;
    startEdge = cyc + 1;
    repeat (DIV - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) sendBit(data[i]);
    sendBit(stopBit);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearObs();
    @(posedge clk);
    valid_q.delete();
    err_q.delete();
    led_high = 0;
  endtask

  initial begin
    int         e;
    int         e0;
    logic [7:0] expCnt;
    logic [7:0] expData;
    logic [7:0] b;
    rec_t       r;

    passed    = 0;
    total     = 0;
    cyc       = 0;
    led_high  = 0;
    both_high = 0;
    expCnt    = 8'h00;
    expData   = 8'h00;
    rst       = 1'b1;
    rx        = 1'b1;

    // Reset held while the line toggles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx = i[0];
    end
    checkOutput("reset_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_ferr", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_led", {31'd0, led_rx}, 32'd0);
    checkOutput("reset_data", {24'd0, rx_data}, 32'h00);
    checkOutput("reset_cnt", {24'd0, rx_cnt}, 32'h00);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clearObs();
    idleCycles(20);
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("post_reset_nostrobe", valid_q.size() + err_q.size(), 32'd0);

    // Single good byte.
    applyStimulus(8'hA5, 1'b1, e);
    idleCycles(40);
    expCnt++;
    expData = 8'hA5;
    checkOutput("a5_count", valid_q.size(), 32'd1);
    if (valid_q.size() > 0) begin
      r = valid_q.pop_front();
      checkOutput("a5_latency", r.cyc, e + LAT);
      checkOutput("a5_data", {24'd0, r.data}, {24'd0, expData});
      checkOutput("a5_cnt", {24'd0, r.cnt}, {24'd0, expCnt});
    end
    checkOutput("a5_no_ferr", err_q.size(), 32'd0);
    checkOutput("a5_led_cycles", led_high, LED_HOLD);
    checkOutput("a5_data_held", {24'd0, rx_data}, {24'd0, expData});
    checkOutput("a5_busy_after", {31'd0, busy}, 32'd0);

    // Short low glitch is rejected at the mid-start check.
    clearObs();
    @(negedge clk);
    rx = 1'b0;
    idleCycles(4);
    rx = 1'b1;
    idleCycles(30);
    checkOutput("glitch_nostrobe", valid_q.size() + err_q.size(), 32'd0);
    checkOutput("glitch_busy", {31'd0, busy}, 32'd0);
    checkOutput("glitch_cnt", {24'd0, rx_cnt}, {24'd0, expCnt});

    // Bad stop bit followed by a held break.
    clearObs();
    applyStimulus(8'h3C, 1'b0, e);
    idleCycles(50);
    checkOutput("break_busy", {31'd0, busy}, 32'd1);
    idleCycles(50);
    @(negedge clk);
    rx = 1'b1;
    idleCycles(20);
    checkOutput("ferr_count", err_q.size(), 32'd1);
    if (err_q.size() > 0) checkOutput("ferr_latency", err_q[0], e + LAT);
    checkOutput("ferr_novalid", valid_q.size(), 32'd0);
    checkOutput("ferr_data", {24'd0, rx_data}, {24'd0, expData});
    checkOutput("ferr_cnt", {24'd0, rx_cnt}, {24'd0, expCnt});
    checkOutput("ferr_busy_after", {31'd0, busy}, 32'd0);
    applyStimulus(8'h31, 1'b1, e);
    idleCycles(10);
    expCnt++;
    expData = 8'h31;
    checkOutput("recover_data", {24'd0, rx_data}, {24'd0, expData});
    checkOutput("recover_cnt", {24'd0, rx_cnt}, {24'd0, expCnt});

    // Back-to-back frames with no idle gap.
    clearObs();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h30 + 8'(i), 1'b1, e);
      if (i == 0) e0 = e;
    end
    idleCycles(20);
    checkOutput("b2b_count", valid_q.size(), 32'd10);
    for (int i = 0; i < 10 && valid_q.size() > 0; i++) begin
      r = valid_q.pop_front();
      expCnt++;
      checkOutput("b2b_time", r.cyc, e0 + LAT + 160 * i);
      checkOutput("b2b_data", {24'd0, r.data}, 32'h30 + i);
      checkOutput("b2b_cnt", {24'd0, r.cnt}, {24'd0, expCnt});
      checkOutput("b2b_led", {31'd0, r.led}, 32'd1);
    end
    checkOutput("b2b_no_ferr", err_q.size(), 32'd0);

    // Reset in the middle of bit 4 of 8'hFF abandons the frame.
    clearObs();
    @(negedge clk);
    rx = 1'b0;
    idleCycles(DIV - 1);
    rx = 1'b1;
    idleCycles(4 * DIV + HALF);
    rst = 1'b1;
    idleCycles(3);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idleCycles(3 * DIV);
    expCnt  = 8'h00;
    expData = 8'h00;
    checkOutput("midreset_nostrobe", valid_q.size() + err_q.size(), 32'd0);
    checkOutput("midreset_cnt", {24'd0, rx_cnt}, 32'h00);
    checkOutput("midreset_busy_after", {31'd0, busy}, 32'd0);

    // 8'h00 then 255 random bytes with random gaps: counter wraps back to 0.
    applyStimulus(8'h00, 1'b1, e);
    idleCycles(5);
    expCnt++;
    checkOutput("zero_count", valid_q.size(), 32'd1);
    if (valid_q.size() > 0) begin
      r = valid_q.pop_front();
      checkOutput("zero_data", {24'd0, r.data}, 32'h00);
      checkOutput("zero_cnt", {24'd0, r.cnt}, {24'd0, expCnt});
    end
    for (int i = 0; i < 255; i++) begin
      b = 8'($urandom_range(0, 255));
      applyStimulus(b, 1'b1, e);
      idleCycles($urandom_range(0, 5));
      expCnt++;
      expData = b;
      if (valid_q.size() == 1) begin
        r = valid_q.pop_front();
        checkOutput("rand_data", {24'd0, r.data}, {24'd0, expData});
        checkOutput("rand_time", r.cyc, e + LAT);
      end else begin
        checkOutput("rand_strobe_count", valid_q.size(), 32'd1);
        valid_q.delete();
      end
    end
    idleCycles(10);
    checkOutput("wrap_cnt", {24'd0, rx_cnt}, 32'h00);
    checkOutput("wrap_model_cnt", {24'd0, rx_cnt}, {24'd0, expCnt});
    checkOutput("wrap_data", {24'd0, rx_data}, {24'd0, expData});
    checkOutput("total_ferr", err_q.size(), 32'd0);
    checkOutput("never_both", both_high, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
